// File: rtl/cpu_pkg.sv
// Shared ISA view for the 16-bit CPU pipeline: opcodes, IR field helpers, sequencer states.
// Latency: n/a (constants and pure combinational helpers only).
// Backpressure: n/a.
// IR layout: [3:0] opcode, [4] immediate flag, [7:5] Rx, [10:8] Ry, [15:11] opcode-specific.
package cpu_pkg;

    localparam int IR_W = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_MV   = 4'h3;
    localparam logic [3:0] OP_MVHI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_J    = 4'h7;
    localparam logic [3:0] OP_JN   = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    function automatic logic [3:0] op(input logic [IR_W-1:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic imm(input logic [IR_W-1:0] ir);
        return ir[4];
    endfunction

    function automatic logic [2:0] rx(input logic [IR_W-1:0] ir);
        return ir[7:5];
    endfunction

    function automatic logic [2:0] ry(input logic [IR_W-1:0] ir);
        return ir[10:8];
    endfunction

    // Opcodes whose result lands in Rx (CMP only updates flags).
    function automatic logic writes_rx(input logic [3:0] opc);
        logic w;
        w = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_MV, OP_MVHI, OP_LD: w = 1'b1;
            default:                               w = 1'b0;
        endcase
        return w;
    endfunction

    // True when instruction ir sources register r as an operand.
    function automatic logic reads_reg(input logic [IR_W-1:0] ir, input logic [2:0] r);
        logic rd_x;
        logic rd_y;
        rd_x = 1'b0;
        rd_y = 1'b0;
        case (op(ir))
            OP_ADD, OP_SUB, OP_CMP: begin
                rd_x = 1'b1;
                rd_y = !imm(ir);
            end
            OP_MV:   rd_y = !imm(ir);
            OP_MVHI: rd_x = 1'b1;
            OP_LD:   rd_y = 1'b1;
            OP_ST: begin
                rd_x = 1'b1;
                rd_y = 1'b1;
            end
            OP_J, OP_JN, OP_JZ, OP_CALL: rd_x = !imm(ir);
            default: begin
                rd_x = 1'b0;
                rd_y = 1'b0;
            end
        endcase
        return (rd_x && (rx(ir) == r)) || (rd_y && (ry(ir) == r));
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Decodes pipeline hazards (dmem hold, taken branch, load-use) from the RR/EX IRs and valids.
// Latency: purely combinational, same cycle.
// Backpressure: none itself; its outputs drive the sequencer's stall/flush decisions.
// Ports: rr_ir_i/ex_ir_i stage IRs, valid_rr_i/valid_ex_i stage valids, br_taken_i and
//        dmem_wait_i raw status; ex_mem_hold_o, taken_o, load_use_o hazard flags.
module hazard_decode
    import cpu_pkg::*;
(
    input  logic [IR_W-1:0] rr_ir_i,
    input  logic [IR_W-1:0] ex_ir_i,
    input  logic            valid_rr_i,
    input  logic            valid_ex_i,
    input  logic            br_taken_i,
    input  logic            dmem_wait_i,
    output logic            ex_mem_hold_o,
    output logic            taken_o,
    output logic            load_use_o
);

    logic [3:0] op_ex;
    logic       ex_is_mem;
    logic       unused_ir_hi;

    assign op_ex     = op(ex_ir_i);
    assign ex_is_mem = (op_ex == OP_LD) || (op_ex == OP_ST);

    assign ex_mem_hold_o = valid_ex_i && ex_is_mem && dmem_wait_i;
    assign taken_o       = valid_ex_i && br_taken_i;
    // An invalid RR slot is a bubble and can never create a dependency.
    assign load_use_o    = valid_ex_i && (op_ex == OP_LD) && writes_rx(op_ex)
                           && valid_rr_i && reads_reg(rr_ir_i, rx(ex_ir_i));

    // Upper IR bits carry no register-dependency information.
    assign unused_ir_hi = ^{rr_ir_i[15:11], ex_ir_i[15:11]};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 4-stage CPU: stage valids, stage enables, bubbles, flushes, perf counters.
// Latency: enables are combinational from state+inputs; valids/counters update on the next posedge.
// Backpressure: imem wait stalls fetch, load-use stalls F/RR, dmem wait freezes the whole pipe.
// Ports: clk/rst (sync, active-high); i_rr_ir/i_ex_ir stage IRs; i_br_taken, i_imem_wait,
//        i_dmem_wait status; o_pc_en/o_pc_load and o_*_en stage enables; o_valid_* stage valids;
//        o_mem_timeout sticky dmem timeout; o_stall_cnt/o_flush_cnt saturating event counters.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IR_W-1:0]  i_rr_ir,
    input  logic [IR_W-1:0]  i_ex_ir,
    input  logic             i_br_taken,
    input  logic             i_imem_wait,
    input  logic             i_dmem_wait,
    output logic             o_pc_en,
    output logic             o_pc_load,
    output logic             o_f_rr_en,
    output logic             o_rr_ex_en,
    output logic             o_ex_wb_en,
    output logic             o_valid_rr,
    output logic             o_valid_ex,
    output logic             o_valid_wb,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [BOOT_W-1:0] boot_q, boot_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              valid_rr_q, valid_rr_d;
    logic              valid_ex_q, valid_ex_d;
    logic              valid_wb_q, valid_wb_d;

    logic ex_mem_hold;
    logic taken;
    logic load_use;

    hazard_decode u_hazard_decode (
        .rr_ir_i       (i_rr_ir),
        .ex_ir_i       (i_ex_ir),
        .valid_rr_i    (valid_rr_q),
        .valid_ex_i    (valid_ex_q),
        .br_taken_i    (i_br_taken),
        .dmem_wait_i   (i_dmem_wait),
        .ex_mem_hold_o (ex_mem_hold),
        .taken_o       (taken),
        .load_use_o    (load_use)
    );

    // FSM next state, stage enables and stage valids.
    always_comb begin
        state_d    = state_q;
        boot_d     = boot_q;
        valid_rr_d = valid_rr_q;
        valid_ex_d = valid_ex_q;
        valid_wb_d = valid_wb_q;
        o_pc_en    = 1'b0;
        o_pc_load  = 1'b0;
        o_f_rr_en  = 1'b0;
        o_rr_ex_en = 1'b0;
        o_ex_wb_en = 1'b0;

        case (state_q)
            S_BOOT: begin
                valid_rr_d = 1'b0;
                valid_ex_d = 1'b0;
                valid_wb_d = 1'b0;
                if (boot_q == BOOT_W'(BOOT_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    boot_d = boot_q + BOOT_W'(1);
                end
            end
            S_RUN, S_MEMWAIT: begin
                if (ex_mem_hold) begin
                    // Freeze everything; WB must not retire the EX->WB content twice.
                    state_d    = S_MEMWAIT;
                    valid_wb_d = 1'b0;
                end else begin
                    // Every remaining case advances RR->EX->WB.
                    state_d    = S_RUN;
                    o_rr_ex_en = 1'b1;
                    o_ex_wb_en = 1'b1;
                    valid_wb_d = valid_ex_q;
                    valid_ex_d = valid_rr_q;
                    if (taken) begin
                        // Redirect fetch; the RR and F instructions are wrong-path.
                        o_pc_load  = 1'b1;
                        o_pc_en    = 1'b1;
                        o_f_rr_en  = 1'b1;
                        valid_rr_d = 1'b0;
                        valid_ex_d = 1'b0;
                    end else if (load_use) begin
                        // Hold F and RR one cycle; WB forwarding then supplies the load data.
                        valid_ex_d = 1'b0;
                    end else if (i_imem_wait) begin
                        o_f_rr_en  = 1'b1;
                        valid_rr_d = 1'b0;
                    end else begin
                        o_pc_en    = 1'b1;
                        o_f_rr_en  = 1'b1;
                        valid_rr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
                boot_d  = '0;
            end
        endcase
    end

    // Performance counters and dmem wait watchdog.
    always_comb begin
        stall_d   = stall_q;
        flush_d   = flush_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (state_q != S_BOOT) begin
            if (!o_pc_en && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (o_pc_load && (flush_q != '1)) begin
                flush_d = flush_q + CNT_W'(1);
            end
            if (ex_mem_hold) begin
                if (wait_q != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                // wait_q counts earlier hold cycles, so this fires on the MEM_TIMEOUT-th one.
                if (wait_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                end
            end else begin
                wait_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            boot_q     <= '0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
            valid_rr_q <= 1'b0;
            valid_ex_q <= 1'b0;
            valid_wb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_q     <= boot_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            valid_rr_q <= valid_rr_d;
            valid_ex_q <= valid_ex_d;
            valid_wb_q <= valid_wb_d;
        end
    end

    assign o_valid_rr    = valid_rr_q;
    assign o_valid_ex    = valid_ex_q;
    assign o_valid_wb    = valid_wb_q;
    assign o_mem_timeout = timeout_q;
    assign o_stall_cnt   = stall_q;
    assign o_flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then random traffic.
// Latency: a reference model advances on each posedge and is compared against the DUT every negedge.
// Backpressure: random imem/dmem waits, taken branches and occasional resets.
module tb_pipe_ctrl;
    import cpu_pkg::*;

    localparam int BOOT = 4;
    localparam int MT   = 4;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    localparam int A_BOOT    = 0;
    localparam int A_HOLD    = 1;
    localparam int A_FLUSH   = 2;
    localparam int A_BUBBLE  = 3;
    localparam int A_FWAIT   = 4;
    localparam int A_ADVANCE = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   i_rr_ir, i_ex_ir;
    logic          i_br_taken, i_imem_wait, i_dmem_wait;
    logic          o_pc_en, o_pc_load, o_f_rr_en, o_rr_ex_en, o_ex_wb_en;
    logic          o_valid_rr, o_valid_ex, o_valid_wb, o_mem_timeout;
    logic [CW-1:0] o_stall_cnt, o_flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .i_rr_ir(i_rr_ir), .i_ex_ir(i_ex_ir),
        .i_br_taken(i_br_taken), .i_imem_wait(i_imem_wait), .i_dmem_wait(i_dmem_wait),
        .o_pc_en(o_pc_en), .o_pc_load(o_pc_load), .o_f_rr_en(o_f_rr_en),
        .o_rr_ex_en(o_rr_ex_en), .o_ex_wb_en(o_ex_wb_en),
        .o_valid_rr(o_valid_rr), .o_valid_ex(o_valid_ex), .o_valid_wb(o_valid_wb),
        .o_mem_timeout(o_mem_timeout), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_boot_left;
    bit m_v[3];        // 0: RR, 1: EX, 2: WB occupancy
    int m_stall, m_flush, m_wrun;
    bit m_tmo;
    bit m_known = 1'b0;

    // Set of registers an instruction sources, as a one-hot mask.
    function automatic logic [7:0] src_mask(input logic [15:0] ir);
        logic [7:0] bx, by;
        logic       ni;
        bx = 8'b1 << ir[7:5];
        by = 8'b1 << ir[10:8];
        ni = !ir[4];
        case (ir[3:0])
            OP_ADD, OP_SUB, OP_CMP:      return bx | (ni ? by : 8'h00);
            OP_MV:                       return ni ? by : 8'h00;
            OP_MVHI:                     return bx;
            OP_LD:                       return by;
            OP_ST:                       return bx | by;
            OP_J, OP_JN, OP_JZ, OP_CALL: return ni ? bx : 8'h00;
            default:                     return 8'h00;
        endcase
    endfunction

    function automatic int classify();
        logic [7:0] sm;
        logic [3:0] eo;
        eo = i_ex_ir[3:0];
        sm = src_mask(i_rr_ir);
        if (m_boot_left > 0) return A_BOOT;
        if (m_v[1] && (eo == OP_LD || eo == OP_ST) && i_dmem_wait) return A_HOLD;
        if (m_v[1] && i_br_taken) return A_FLUSH;
        if (m_v[1] && eo == OP_LD && m_v[0] && sm[i_ex_ir[7:5]]) return A_BUBBLE;
        if (i_imem_wait) return A_FWAIT;
        return A_ADVANCE;
    endfunction

    always @(posedge clk) begin
        int a;
        if (rst) begin
            m_boot_left = BOOT;
            m_v         = '{0, 0, 0};
            m_stall     = 0;
            m_flush     = 0;
            m_wrun      = 0;
            m_tmo       = 1'b0;
            m_known     = 1'b1;
        end else if (m_known) begin
            a = classify();
            if (a == A_BOOT) begin
                m_boot_left--;
            end else begin
                if (!(a == A_FLUSH || a == A_ADVANCE)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                if (a == A_FLUSH) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                if (a == A_HOLD) begin
                    m_wrun++;
                    if (m_wrun >= MT) m_tmo = 1'b1;
                    m_v[2] = 1'b0;
                end else begin
                    m_wrun = 0;
                    m_v[2] = m_v[1];
                    m_v[1] = (a == A_FLUSH || a == A_BUBBLE) ? 1'b0 : m_v[0];
                    m_v[0] = (a == A_ADVANCE) ? 1'b1 : (a == A_BUBBLE) ? m_v[0] : 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int a;
        if (m_known) begin
            a = classify();
            chk("pc_en",     o_pc_en,     (a == A_FLUSH || a == A_ADVANCE));
            chk("pc_load",   o_pc_load,   (a == A_FLUSH));
            chk("f_rr_en",   o_f_rr_en,   (a == A_FLUSH || a == A_FWAIT || a == A_ADVANCE));
            chk("rr_ex_en",  o_rr_ex_en,  (a != A_BOOT && a != A_HOLD));
            chk("ex_wb_en",  o_ex_wb_en,  (a != A_BOOT && a != A_HOLD));
            chk("valid_rr",  o_valid_rr,  m_v[0]);
            chk("valid_ex",  o_valid_ex,  m_v[1]);
            chk("valid_wb",  o_valid_wb,  m_v[2]);
            chk("timeout",   o_mem_timeout, m_tmo);
            chk("stall_cnt", o_stall_cnt, m_stall);
            chk("flush_cnt", o_flush_cnt, m_flush);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] mk(input logic [3:0] o, input logic [2:0] x,
                                       input logic [2:0] y, input logic im);
        return {5'd0, y, x, im, o};
    endfunction

    function automatic logic [15:0] rnd_ir();
        logic [3:0] o;
        o = ($urandom_range(0, 3) == 0) ? OP_LD : 4'($urandom_range(0, 15));
        return {5'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom), o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rr_ir     = mk(OP_NOP, 3'd0, 3'd0, 1'b0);
        i_ex_ir     = mk(OP_NOP, 3'd0, 3'd0, 1'b0);
        i_br_taken  = 1'b0;
        i_imem_wait = 1'b0;
        i_dmem_wait = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;                                 // cycle 0 of boot
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("boot_pc_en",    o_pc_en,    (k >= 4));
            chk("boot_valid_rr", o_valid_rr, (k >= 5));
            tick();
        end
        tick();                                     // cycle 7: pipe full
        // load-use: LD r1,[r2] in EX, ADD r3,r1 in RR
        i_ex_ir = mk(OP_LD, 3'd1, 3'd2, 1'b0);
        i_rr_ir = mk(OP_ADD, 3'd3, 3'd1, 1'b0);
        @(negedge clk);
        chk("lu_pc_en",    o_pc_en,    0);
        chk("lu_f_rr_en",  o_f_rr_en,  0);
        chk("lu_rr_ex_en", o_rr_ex_en, 1);
        tick();
        idle();
        @(negedge clk);
        chk("lu_bubble_ex", o_valid_ex,  0);
        chk("lu_rr_held",   o_valid_rr,  1);
        chk("lu_stall_cnt", o_stall_cnt, 1);
        tick();
        // immediate form reads only Rx (r3): no stall
        i_ex_ir = mk(OP_LD, 3'd1, 3'd2, 1'b0);
        i_rr_ir = mk(OP_ADD, 3'd3, 3'd5, 1'b1);
        @(negedge clk);
        chk("imm_valid_ex", o_valid_ex, 1);
        chk("imm_pc_en",    o_pc_en,    1);
        tick();
        // taken JZ in EX
        idle();
        i_ex_ir    = mk(OP_JZ, 3'd4, 3'd0, 1'b1);
        i_br_taken = 1'b1;
        @(negedge clk);
        chk("br_pc_load", o_pc_load,   1);
        chk("br_pc_en",   o_pc_en,     1);
        chk("br_flush0",  o_flush_cnt, 0);
        chk("br_vrr_pre", o_valid_rr,  1);
        tick();
        idle();
        @(negedge clk);
        chk("br_vrr",    o_valid_rr,  0);
        chk("br_vex",    o_valid_ex,  0);
        chk("br_vwb",    o_valid_wb,  1);
        chk("br_flush1", o_flush_cnt, 1);
        tick();
        tick();
        tick();                                     // cycle 14: RR/EX/WB valid again
        // ST in EX with 3 dmem wait cycles
        i_ex_ir     = mk(OP_ST, 3'd1, 3'd2, 1'b0);
        i_dmem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_pc_en",    o_pc_en,    0);
            chk("st_f_rr_en",  o_f_rr_en,  0);
            chk("st_rr_ex_en", o_rr_ex_en, 0);
            chk("st_ex_wb_en", o_ex_wb_en, 0);
            if (i > 0) begin
                chk("st_valid_wb", o_valid_wb, 0);
                chk("st_valid_ex", o_valid_ex, 1);
            end
            tick();
        end
        i_dmem_wait = 1'b0;
        @(negedge clk);
        chk("st_resume_pc_en", o_pc_en,       1);
        chk("st_resume_ex_wb", o_ex_wb_en,    1);
        chk("st_stall_cnt",    o_stall_cnt,   4);
        chk("st_no_timeout",   o_mem_timeout, 0);
        tick();
        // timeout: LD in EX, dmem wait held 6 cycles
        i_ex_ir     = mk(OP_LD, 3'd1, 3'd2, 1'b0);
        i_dmem_wait = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("to_timeout", o_mem_timeout, (i >= 4));
            tick();
        end
        i_dmem_wait = 1'b0;
        @(negedge clk);
        chk("to_sticky0", o_mem_timeout, 1);
        tick();
        // rst during S_MEMWAIT with a load-use pending
        i_ex_ir     = mk(OP_LD, 3'd1, 3'd2, 1'b0);
        i_rr_ir     = mk(OP_ADD, 3'd3, 3'd1, 1'b0);
        i_dmem_wait = 1'b1;
        @(negedge clk);
        chk("to_sticky1", o_mem_timeout, 1);
        tick();
        tick();
        @(negedge clk);
        chk("mw_rr_ex_en", o_rr_ex_en, 0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_pc_en",    o_pc_en,       0);
        chk("rst_pc_load",  o_pc_load,     0);
        chk("rst_f_rr_en",  o_f_rr_en,     0);
        chk("rst_rr_ex_en", o_rr_ex_en,    0);
        chk("rst_ex_wb_en", o_ex_wb_en,    0);
        chk("rst_valids",   {o_valid_rr, o_valid_ex, o_valid_wb}, 0);
        chk("rst_timeout",  o_mem_timeout, 0);
        chk("rst_stall",    o_stall_cnt,   0);
        chk("rst_flush",    o_flush_cnt,   0);
        rst = 1'b0;
        idle();
        tick();
        // random traffic; EX IR lingers so long dmem waits and saturation occur
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            i_rr_ir = rnd_ir();
            if ($urandom_range(0, 1) == 0) i_ex_ir = rnd_ir();
            i_br_taken  = ($urandom_range(0, 99) < 12);
            i_imem_wait = ($urandom_range(0, 99) < 20);
            i_dmem_wait = ($urandom_range(0, 99) < 40);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
